// File: rtl/riscv_pkg.sv
// Shared RV32I types for the pipeline: decoded operations, writeback port,
// MEM-stage FSM states and load/store classification helpers.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [5:0] {
    UNKNOWN = 6'd0,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, ECALL, EBREAK
  } op_e;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
    logic            valid;
  } rd_port_t;

  typedef enum logic [1:0] {
    MEM_IDLE        = 2'd0,
    MEM_WAIT_GNT    = 2'd1,
    MEM_WAIT_RVALID = 2'd2
  } mem_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic is_load(input op_e op);
    case (op)
      LB, LH, LW, LBU, LHU: is_load = 1'b1;
      default:              is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input op_e op);
    case (op)
      SB, SH, SW: is_store = 1'b1;
      default:    is_store = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_lsu_align.sv
// Combinational lane logic: store byte enables / lane replication / alignment
// check for the current op, and load extraction for the outstanding load.
module lsu_align
  import riscv_pkg::*;
(
  input  op_e             op,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] wdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] lane_wdata,
  output logic            misaligned,
  input  op_e             ld_op,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store lanes and alignment check
  always_comb begin
    be         = BE_WORD;
    lane_wdata = wdata;
    misaligned = 1'b0;
    case (op)
      SB: begin
        be         = BE_BYTE << off;
        lane_wdata = {4{wdata[7:0]}};
      end
      SH: begin
        be         = BE_HALF << off;
        lane_wdata = {2{wdata[15:0]}};
        misaligned = off[0];
      end
      SW:      misaligned = (off != 2'b00);
      LH, LHU: misaligned = off[0];
      LW:      misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // Byte/half selection and extension of the returned word
  always_comb begin
    case (ld_off)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (ld_off[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (ld_op)
      LB:      ld_data = {{24{byte_s[7]}}, byte_s};
      LBU:     ld_data = {24'd0, byte_s};
      LH:      ld_data = {{16{half_s[15]}}, half_s};
      LHU:     ld_data = {16'd0, half_s};
      LW:      ld_data = rdata;
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// RV32I MEM stage: req/gnt/rvalid data-memory access FSM with timeout,
// upstream stall generation and the MEM-WB pipeline register.
module memory_stage
  import riscv_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [XLEN-1:0] pcM_i,
  input  logic [XLEN-1:0] instrM_i,
  input  op_e             operationM_i,
  input  rd_port_t        rdM_port_i,
  input  logic            memM_wrt_ena_i,
  input  logic [XLEN-1:0] memM_addr_i,
  input  logic [XLEN-1:0] memM_wdata_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            stallM_o,
  output logic            misalign_o,
  output logic            access_err_o,
  output logic [XLEN-1:0] pcM_o,
  output logic [XLEN-1:0] instrM_o,
  output op_e             operationM_o,
  output rd_port_t        rdM_port_o
);

  localparam int               CNT_W      = $clog2(MAX_WAIT + 2);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam bit               TIMEOUT_EN = (MAX_WAIT != 32'sd0);

  mem_state_e      state_r, state_d_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic            lat_we_r;
  logic [XLEN-1:0] lat_addr_r, lat_wdata_r;
  logic [3:0]      lat_be_r;
  op_e             lat_op_r;
  logic [1:0]      lat_off_r;

  logic            ld_s, st_s, mem_op_s, misalign_s, misalign_evt_s, bubble_s;
  logic            timeout_s, req_s, stall_s, complete_s;
  logic            we_s;
  logic [XLEN-1:0] addr_s, wdata_s;
  logic [3:0]      be_s, st_be_s;
  logic [XLEN-1:0] st_wdata_s, ld_data_s;
  rd_port_t        wb_rd_s;

  lsu_align u_align (
    .op         (operationM_i),
    .off        (memM_addr_i[1:0]),
    .wdata      (memM_wdata_i),
    .be         (st_be_s),
    .lane_wdata (st_wdata_s),
    .misaligned (misalign_s),
    .ld_op      (lat_op_r),
    .ld_off     (lat_off_r),
    .rdata      (dmem_rdata_i),
    .ld_data    (ld_data_s)
  );

  assign ld_s           = is_load(operationM_i);
  assign st_s           = is_store(operationM_i) & memM_wrt_ena_i;
  assign mem_op_s       = ld_s | st_s;
  assign misalign_evt_s = (state_r == MEM_IDLE) & mem_op_s & misalign_s;
  assign timeout_s      = TIMEOUT_EN && (state_r != MEM_IDLE) && (wait_cnt_r == WAIT_LIMIT);
  // A squashed store never reaches memory and must not retire either.
  assign bubble_s       = stall_s | misalign_evt_s | (is_store(operationM_i) & ~memM_wrt_ena_i);

  // Request decode, completion and next-state selection
  always_comb begin
    state_d_s  = state_r;
    req_s      = 1'b0;
    stall_s    = 1'b0;
    complete_s = 1'b0;
    we_s       = st_s;
    addr_s     = {memM_addr_i[XLEN-1:2], 2'b00};
    be_s       = ld_s ? BE_WORD : st_be_s;
    wdata_s    = st_wdata_s;
    case (state_r)
      MEM_IDLE: begin
        if (mem_op_s && !misalign_s) begin
          req_s = 1'b1;
          if (dmem_gnt_i && st_s) begin
            complete_s = 1'b1;
          end else if (dmem_gnt_i) begin
            state_d_s = MEM_WAIT_RVALID;
            stall_s   = 1'b1;
          end else begin
            state_d_s = MEM_WAIT_GNT;
            stall_s   = 1'b1;
          end
        end else begin
          state_d_s = MEM_IDLE;
        end
      end
      MEM_WAIT_GNT: begin
        we_s    = lat_we_r;
        addr_s  = lat_addr_r;
        be_s    = lat_be_r;
        wdata_s = lat_wdata_r;
        if (timeout_s) begin
          state_d_s = MEM_IDLE;
        end else if (dmem_gnt_i && lat_we_r) begin
          req_s      = 1'b1;
          complete_s = 1'b1;
          state_d_s  = MEM_IDLE;
        end else if (dmem_gnt_i) begin
          req_s     = 1'b1;
          stall_s   = 1'b1;
          state_d_s = MEM_WAIT_RVALID;
        end else begin
          req_s   = 1'b1;
          stall_s = 1'b1;
        end
      end
      MEM_WAIT_RVALID: begin
        we_s    = lat_we_r;
        addr_s  = lat_addr_r;
        be_s    = lat_be_r;
        wdata_s = lat_wdata_r;
        if (timeout_s) begin
          state_d_s = MEM_IDLE;
        end else if (dmem_rvalid_i) begin
          complete_s = 1'b1;
          state_d_s  = MEM_IDLE;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: state_d_s = MEM_IDLE;
    endcase
  end

  // Writeback port: timed-out accesses drop rd, completed loads carry memory data
  always_comb begin
    wb_rd_s = rdM_port_i;
    if (timeout_s) begin
      wb_rd_s.valid = 1'b0;
    end else if (complete_s && (state_r == MEM_WAIT_RVALID)) begin
      wb_rd_s.data = ld_data_s;
    end else begin
      wb_rd_s = rdM_port_i;
    end
  end

  // Reset gating lets the request and stall drop without waiting for a clock.
  assign dmem_req_o   = req_s & rstn_i;
  assign stallM_o     = stall_s & rstn_i;
  assign dmem_we_o    = we_s;
  assign dmem_addr_o  = addr_s;
  assign dmem_be_o    = be_s;
  assign dmem_wdata_o = wdata_s;

  // FSM state, wait counter, latched request and MEM-WB register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r      <= MEM_IDLE;
      wait_cnt_r   <= {CNT_W{1'b0}};
      lat_we_r     <= 1'b0;
      lat_addr_r   <= {XLEN{1'b0}};
      lat_wdata_r  <= {XLEN{1'b0}};
      lat_be_r     <= 4'b0000;
      lat_op_r     <= UNKNOWN;
      lat_off_r    <= 2'b00;
      misalign_o   <= 1'b0;
      access_err_o <= 1'b0;
      pcM_o        <= {XLEN{1'b0}};
      instrM_o     <= {XLEN{1'b0}};
      operationM_o <= UNKNOWN;
      rdM_port_o   <= '0;
    end else begin
      state_r      <= state_d_s;
      wait_cnt_r   <= (TIMEOUT_EN && stall_s) ? wait_cnt_r + CNT_ONE : {CNT_W{1'b0}};
      misalign_o   <= misalign_evt_s;
      access_err_o <= timeout_s;
      if (state_r == MEM_IDLE) begin
        lat_we_r    <= we_s;
        lat_addr_r  <= addr_s;
        lat_wdata_r <= wdata_s;
        lat_be_r    <= be_s;
        lat_op_r    <= operationM_i;
        lat_off_r   <= memM_addr_i[1:0];
      end
      if (bubble_s) begin
        pcM_o        <= {XLEN{1'b0}};
        instrM_o     <= {XLEN{1'b0}};
        operationM_o <= UNKNOWN;
        rdM_port_o   <= '0;
      end else begin
        pcM_o        <= pcM_i;
        instrM_o     <= instrM_i;
        operationM_o <= operationM_i;
        rdM_port_o   <= wb_rd_s;
      end
    end
  end

endmodule
